// File: rtl/cordic_pkg.sv
// Shared types and helpers for the CORDIC downscale arbiter: FSM state, default widths and
// the round-robin pick function.
package cordic_pkg;

    typedef enum logic {IDLE, BURST} state_t;

    localparam int unsigned CORDIC_WIDTH_DEF = 22;
    localparam int unsigned DATA_WIDTH_DEF   = 16;

    // rr_next works on a fixed 8-wide vector; callers zero-pad, so wrapping modulo 8
    // lands on the same requester as wrapping modulo NUM_REQ.
    localparam int unsigned RR_MAX_REQ = 8;
    localparam int unsigned RR_IDX_W   = 3;

    function automatic logic [RR_IDX_W-1:0] rr_next(input logic [RR_MAX_REQ-1:0] vld,
                                                    input logic [RR_IDX_W-1:0]   ptr);
        logic [RR_IDX_W-1:0] idx;
        logic [RR_IDX_W-1:0] pick;
        pick = ptr;
        // Scan from the far end so the closest set bit above ptr is written last.
        for (int i = RR_MAX_REQ - 1; i >= 0; i--) begin
            idx = ptr + RR_IDX_W'(i);
            if (vld[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or above the pointer, wrapping.
module rr_arbiter
    import cordic_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req_vld,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [ID_WIDTH-1:0] grant,
    output logic                any_vld
);

    logic [RR_MAX_REQ-1:0] vld_pad;
    logic [RR_IDX_W-1:0]   ptr_pad;
    logic [RR_IDX_W-1:0]   pick;

    always_comb begin
        vld_pad = RR_MAX_REQ'(req_vld);
        ptr_pad = RR_IDX_W'(ptr);
        pick    = rr_next(vld_pad, ptr_pad);
        grant   = ID_WIDTH'(pick);
        any_vld = |req_vld;
    end

endmodule

// File: rtl/cordic_downscale_arbiter.sv
// Round-robin burst arbiter in front of a shared CORDIC_WIDTH->DATA_WIDTH downscale stage.
// Define DOWNSCALE_ROUND_SAT_EN for round-half-up with positive saturation instead of truncation.
module cordic_downscale_arbiter
    import cordic_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned CORDIC_WIDTH = CORDIC_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int unsigned ID_WIDTH     = 2
) (
    input  logic                            clk,
    input  logic                            nreset,
    input  logic [NUM_REQ-1:0]              req_vld,
    input  logic [NUM_REQ-1:0]              req_last,
    input  logic [NUM_REQ*CORDIC_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]              req_rdy,
    output logic                            out_vld,
    input  logic                            out_rdy,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [ID_WIDTH-1:0]             out_id,
    output logic                            out_last
);

    localparam int unsigned SHIFT = CORDIC_WIDTH - DATA_WIDTH;

    state_t                  state_q;
    logic [ID_WIDTH-1:0]     grant_q;
    logic [ID_WIDTH-1:0]     ptr_q;
    logic [ID_WIDTH-1:0]     arb_grant;
    logic [ID_WIDTH-1:0]     ptr_next;
    logic                    any_vld;
    logic [CORDIC_WIDTH-1:0] sel_data;
    logic                    sel_vld;
    logic                    sel_last;
    logic                    take;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   ds_data;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_arbiter (
        .req_vld (req_vld),
        .ptr     (ptr_q),
        .grant   (arb_grant),
        .any_vld (any_vld)
    );

    assign ptr_next = (arb_grant == ID_WIDTH'(NUM_REQ - 1)) ? '0 : arb_grant + 1'b1;

    // Output slot is free when empty or being drained this cycle.
    assign take = ~out_vld | out_rdy;

    always_comb begin
        sel_data = '0;
        sel_vld  = 1'b0;
        sel_last = 1'b0;
        req_rdy  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_q == ID_WIDTH'(i)) begin
                sel_data   = req_data[i*CORDIC_WIDTH +: CORDIC_WIDTH];
                sel_vld    = req_vld[i];
                sel_last   = req_last[i];
                req_rdy[i] = (state_q == BURST) & take;
            end
        end
    end

    assign accept = (state_q == BURST) & sel_vld & take;

`ifdef DOWNSCALE_ROUND_SAT_EN
    localparam logic [CORDIC_WIDTH:0] HALF_LSB = (CORDIC_WIDTH + 1)'(1) << (SHIFT - 1);

    logic [CORDIC_WIDTH:0] rnd_sum;
    logic [DATA_WIDTH:0]   rnd_top;
    logic                  unused_rnd_low;

    always_comb begin
        rnd_sum = {sel_data[CORDIC_WIDTH-1], sel_data} + HALF_LSB;
        rnd_top = rnd_sum[CORDIC_WIDTH -: DATA_WIDTH + 1];
        // Adding a positive half-LSB can only overflow toward +max.
        if (rnd_top[DATA_WIDTH] != rnd_top[DATA_WIDTH-1]) begin
            ds_data = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
        end else begin
            ds_data = rnd_top[DATA_WIDTH-1:0];
        end
    end

    assign unused_rnd_low = ^rnd_sum[SHIFT-1:0];
`else
    logic unused_trunc_low;

    assign ds_data          = sel_data[CORDIC_WIDTH-1 -: DATA_WIDTH];
    assign unused_trunc_low = ^sel_data[SHIFT-1:0];
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            ptr_q    <= '0;
            out_vld  <= 1'b0;
            out_data <= '0;
            out_id   <= '0;
            out_last <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_vld) begin
                        grant_q <= arb_grant;
                        ptr_q   <= ptr_next;
                        state_q <= BURST;
                    end
                end
                BURST: begin
                    if (accept && sel_last) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (accept) begin
                out_vld  <= 1'b1;
                out_data <= ds_data;
                out_id   <= grant_q;
                out_last <= sel_last;
            end else if (out_rdy) begin
                out_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cordic_downscale_arbiter.sv
// Directed scoreboard bench for cordic_downscale_arbiter (honours DOWNSCALE_ROUND_SAT_EN).
module tb_cordic_downscale_arbiter;

    localparam int NR   = 4;
    localparam int CW   = 22;
    localparam int DW   = 16;
    localparam int IW   = 2;
    localparam int MAXB = 8;

    logic              clk = 1'b0;
    logic              nreset;
    logic [NR-1:0]     req_vld;
    logic [NR-1:0]     req_last;
    logic [NR*CW-1:0]  req_data;
    logic [NR-1:0]     req_rdy;
    logic              out_vld;
    logic              out_rdy;
    logic [DW-1:0]     out_data;
    logic [IW-1:0]     out_id;
    logic              out_last;

    always #5 clk = ~clk;

    cordic_downscale_arbiter #(
        .NUM_REQ      (NR),
        .CORDIC_WIDTH (CW),
        .DATA_WIDTH   (DW),
        .ID_WIDTH     (IW)
    ) dut (
        .clk      (clk),
        .nreset   (nreset),
        .req_vld  (req_vld),
        .req_last (req_last),
        .req_data (req_data),
        .req_rdy  (req_rdy),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_id   (out_id),
        .out_last (out_last)
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic          last;
        logic [3:0]    gap;
    } exp_t;

    exp_t          sb[$];
    logic [CW-1:0] bdata[NR][MAXB];
    int            nb[NR];
    int            idx[NR];
    logic [NR-1:0] drop;
    logic [NR-1:0] hs;
    int            cyc;
    int            last_fire;
    int            first_out;
    int            n_asserts;
    int            n_fails;

    function automatic logic [DW-1:0] model_ds(input logic [CW-1:0] x);
        int v;
        int r;
        v = $signed(x);
`ifdef DOWNSCALE_ROUND_SAT_EN
        r = (v + (1 << (CW - DW - 1))) >>> (CW - DW);
        if (r > (1 << (DW - 1)) - 1) r = (1 << (DW - 1)) - 1;
`else
        r = v >>> (CW - DW);
`endif
        return r[DW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int r = 0; r < NR; r++) begin
            if (idx[r] < nb[r]) begin
                req_vld[r]             = !drop[r];
                req_data[r*CW +: CW]   = bdata[r][idx[r]];
                req_last[r]            = (idx[r] == nb[r] - 1);
            end else begin
                req_vld[r]             = 1'b0;
                req_data[r*CW +: CW]   = '0;
                req_last[r]            = 1'b0;
            end
        end
    endtask

    // Push expected outputs for requester r; strict adds cycle-gap checks.
    task automatic push_burst(input int r, input bit strict, input bit first);
        exp_t e;
        for (int k = 0; k < nb[r]; k++) begin
            e.id   = IW'(r);
            e.data = model_ds(bdata[r][k]);
            e.last = (k == nb[r] - 1);
            e.gap  = !strict ? 4'd0 : (k > 0) ? 4'd1 : first ? 4'd0 : 4'd2;
            sb.push_back(e);
        end
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        hs = req_vld & req_rdy;
        chk("rdy_onehot", 32'($countones(req_rdy) <= 1), 32'd1);
        if (out_vld) begin
            if (first_out < 0) first_out = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_beat", 32'(sb.size()), 32'd1);
            end else begin
                e = sb[0];
                chk("out_data", 32'(out_data), 32'(e.data));
                chk("out_id", 32'(out_id), 32'(e.id));
                chk("out_last", 32'(out_last), 32'(e.last));
                if (out_rdy) begin
                    void'(sb.pop_front());
                    if (e.gap != 0) chk("beat_gap", 32'(cyc - last_fire), 32'(e.gap));
                    last_fire = cyc;
                end else begin
                    chk("stall_rdy", 32'(req_rdy), 32'd0);
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int r = 0; r < NR; r++) if (hs[r]) idx[r]++;
        drive();
    endtask

    function automatic bit all_done();
        for (int r = 0; r < NR; r++) if (idx[r] < nb[r]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run(input int max_cyc, input bit rand_rdy, input bit rand_drop);
        int k;
        k = 0;
        while ((!all_done() || sb.size() != 0) && k < max_cyc) begin
            out_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int r = 0; r < NR; r++)
                drop[r] = rand_drop && idx[r] > 0 && idx[r] < nb[r] && $urandom_range(0, 3) == 0;
            drive();
            step();
            k++;
        end
        chk("run_timeout", 32'(k < max_cyc), 32'd1);
    endtask

    task automatic clear_stim();
        for (int r = 0; r < NR; r++) begin
            nb[r]  = 0;
            idx[r] = 0;
        end
        drop = '0;
        sb.delete();
        drive();
    endtask

    task automatic do_reset();
        nreset  = 1'b0;
        out_rdy = 1'b1;
        clear_stim();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_req_rdy", 32'(req_rdy), 32'd0);
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        exp_t e;
        int   start;
        n_asserts = 0;
        n_fails   = 0;
        cyc       = 0;
        last_fire = 0;
        req_vld   = '0;
        req_last  = '0;
        req_data  = '0;

        // Single 3-beat burst from requester 1, constants checked directly.
        do_reset();
        nb[1] = 3;
        bdata[1][0] = 22'h100040;
        bdata[1][1] = 22'h3FFFC0;
        bdata[1][2] = 22'h200000;
        e.id = 2'd1; e.gap = 4'd0;
        e.data = 16'h4001; e.last = 1'b0; sb.push_back(e);
        e.gap = 4'd1;
        e.data = 16'hFFFF; e.last = 1'b0; sb.push_back(e);
        e.data = 16'h8000; e.last = 1'b1; sb.push_back(e);
        first_out = -1;
        start = cyc;
        run(40, 1'b0, 1'b0);
        chk("first_latency", 32'(first_out - start), 32'd2);

        // All four requesters with 2-beat bursts: order 0,0,1,1,2,2,3,3, one bubble between.
        do_reset();
        for (int r = 0; r < NR; r++) begin
            nb[r] = 2;
            for (int k = 0; k < 2; k++) bdata[r][k] = CW'($urandom);
            push_burst(r, 1'b1, r == 0);
        end
        run(60, 1'b0, 1'b0);

        // Downstream stall of 5 cycles in the middle of a 6-beat burst.
        do_reset();
        nb[3] = 6;
        for (int k = 0; k < 6; k++) bdata[3][k] = CW'($urandom);
        push_burst(3, 1'b0, 1'b1);
        for (int k = 0; k < 20 && idx[3] < 3; k++) step();
        out_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_vld", 32'(out_vld), 32'd1);
        end
        run(40, 1'b0, 1'b0);

        // Reset during the 2nd beat from requester 2; afterwards pointer is back at 0.
        do_reset();
        nb[2] = 4;
        for (int k = 0; k < 4; k++) bdata[2][k] = CW'($urandom);
        push_burst(2, 1'b0, 1'b1);
        for (int k = 0; k < 20 && idx[2] < 1; k++) step();
        #2;
        nreset = 1'b0;
        #1;
        chk("mid_rst_out_vld", 32'(out_vld), 32'd0);
        chk("mid_rst_out_data", 32'(out_data), 32'd0);
        chk("mid_rst_out_id", 32'(out_id), 32'd0);
        chk("mid_rst_out_last", 32'(out_last), 32'd0);
        chk("mid_rst_req_rdy", 32'(req_rdy), 32'd0);
        clear_stim();
        nb[0] = 2;
        nb[3] = 2;
        for (int k = 0; k < 2; k++) begin
            bdata[0][k] = CW'($urandom);
            bdata[3][k] = CW'($urandom);
        end
        push_burst(0, 1'b0, 1'b1);
        push_burst(3, 1'b0, 1'b0);
        drive();
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        run(40, 1'b0, 1'b0);

        // Rounding/saturation corner values plus negatives.
        do_reset();
        nb[0] = 4;
        bdata[0][0] = 22'h1FFFE0;
        bdata[0][1] = 22'h000020;
        bdata[0][2] = 22'h3FFFE0;
        bdata[0][3] = 22'h2000A0;
        e.id = 2'd0; e.gap = 4'd0; e.last = 1'b0;
        e.data = 16'h7FFF; sb.push_back(e);
`ifdef DOWNSCALE_ROUND_SAT_EN
        e.data = 16'h0001; sb.push_back(e);
        e.data = 16'h0000; sb.push_back(e);
        e.data = 16'h8003; e.last = 1'b1; sb.push_back(e);
`else
        e.data = 16'h0000; sb.push_back(e);
        e.data = 16'hFFFF; sb.push_back(e);
        e.data = 16'h8002; e.last = 1'b1; sb.push_back(e);
`endif
        run(40, 1'b0, 1'b0);

        // Random data, burst lengths (incl. single beat), backpressure and mid-burst valid gaps.
        do_reset();
        for (int r = 0; r < NR; r++) begin
            nb[r] = (r == 1) ? 1 : int'($urandom_range(1, 6));
            for (int k = 0; k < nb[r]; k++) bdata[r][k] = CW'($urandom);
            push_burst(r, 1'b0, 1'b1);
        end
        run(300, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/cordic_downscale_arbiter.md
Name: cordic_downscale_arbiter

Overview:
Shares one CORDIC-to-data-width downscale stage among NUM_REQ CORDIC result streams. Each requester sends a burst of vector elements using valid/ready, ending with a last flag. The block grants requesters round-robin and holds the grant for a whole burst. It drops each element from CORDIC_WIDTH to DATA_WIDTH and emits it through a registered valid/ready output, tagged with the requester ID. It sits between the parallel CORDIC vector-op units and the downstream FastICA vector accumulator.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CORDIC_WIDTH, 22, input element width (signed)
DATA_WIDTH, 16, output element width (signed); must be < CORDIC_WIDTH
ID_WIDTH, 2, requester ID width; must be >= clog2(NUM_REQ)

Ports:
clk  in  1  clock
nreset  in  1  reset, asynchronous, active-low
req_vld  in  NUM_REQ  per-requester element valid
req_last  in  NUM_REQ  per-requester last element of burst
req_data  in  NUM_REQ*CORDIC_WIDTH  packed elements; requester i at [i*CORDIC_WIDTH +: CORDIC_WIDTH]
req_rdy  out  NUM_REQ  per-requester accept; at most one bit high
out_vld  out  1  output element valid
out_rdy  in  1  downstream accept
out_data  out  DATA_WIDTH  downscaled element
out_id  out  ID_WIDTH  index of the source requester
out_last  out  1  last element of burst

Behaviour:
- Reset values:
  - req_rdy=0, out_vld=0, out_data=0, out_id=0, out_last=0.
  - FSM=IDLE, round-robin pointer=0.
- FSM states: IDLE and BURST.
- IDLE:
  - If any req_vld is high, pick the first set bit scanning from the pointer upward, modulo NUM_REQ.
  - Register that index as grant, set pointer = grant+1 mod NUM_REQ, move to BURST.
  - If no req_vld is high, stay in IDLE.
  - Arbitration takes 1 cycle; req_rdy stays 0 in IDLE.
- BURST:
  - req_rdy[grant] = ~out_vld | out_rdy; every other req_rdy bit is 0.
  - A beat is accepted when req_vld[grant] & req_rdy[grant].
  - An accepted beat loads the output register on the next edge: out_data=downscale(req_data[grant]), out_id=grant, out_last=req_last[grant], out_vld=1.
  - Accepting a beat with req_last=1 returns the FSM to IDLE. This leaves one arbitration bubble between bursts.
- Output register:
  - Holds its contents while out_vld & ~out_rdy.
  - Clears out_vld when out_rdy is high and no new beat is accepted.
  - Latency from accept to out_vld is 1 cycle. Sustained throughput is 1 beat/cycle.
- Downscale rule: out_data = x[CORDIC_WIDTH-1 : CORDIC_WIDTH-DATA_WIDTH], i.e. truncation toward negative infinity.
- Boundary conditions:
  - Granted requester drops req_vld mid-burst: the grant holds and the output stalls. There is no timeout.
  - Requesters that are not granted are ignored. Their req_vld may toggle freely.
  - A single-beat burst (req_last on the first beat) is legal and takes IDLE->BURST->IDLE.
  - All NUM_REQ requesters continuously valid: grants go 0,1,2,3,0,...
  - nreset asserted mid-burst: everything returns to reset values immediately, the in-flight element is discarded, and the pointer returns to 0.
  - req_last arriving on a non-accepted cycle has no effect.

Optional Feature:
Macro DOWNSCALE_ROUND_SAT_EN.
- Defined:
  - Add 2^(CORDIC_WIDTH-DATA_WIDTH-1) to x in CORDIC_WIDTH+1 bits, then take the top DATA_WIDTH+1 bits.
  - If these do not fit in DATA_WIDTH, saturate to +(2^(DATA_WIDTH-1))-1.
  - Negative values cannot overflow under this rule.
- Undefined: plain truncation as above. No extra logic.
- Latency is identical in both modes.

Decomposition:
- Package cordic_pkg holds:
  - FSM state typedef (IDLE, BURST).
  - Default width constants CORDIC_WIDTH_DEF=22 and DATA_WIDTH_DEF=16.
  - Function rr_next(vld, ptr), returning the grant index.
- Sub-module rr_arbiter: combinational round-robin pick from req_vld and pointer, output index and any_vld.
- Downscale, FSM and output register stay in the top module.

Test Plan:
- Single requester 1: 3-beat burst with req_data = 0x100040, 0x3FFFC0, 0x200000 (out_rdy=1) -> out_data = 0x4001, 0xFFFF, 0x8000; out_id=1; out_last only on the 3rd beat; first out_vld 2 cycles after req_vld.
- All 4 requesters each holding a 2-beat burst -> out_id sequence 0,0,1,1,2,2,3,3, with exactly one idle cycle between bursts.
- out_rdy held low 5 cycles mid-burst -> out_data stable, req_rdy[grant]=0 while out_vld=1; no beat lost or duplicated after release.
- Assert nreset during the 2nd beat of a burst from requester 2 -> all outputs 0 at once; after release, requester 0 is granted first if it is valid.
- DOWNSCALE_ROUND_SAT_EN defined: input 0x1FFFE0 -> 0x7FFF (saturated); input 0x000020 -> 0x0001 (rounded up). Undefined: the same inputs give 0x7FFF and 0x0000.
